// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU memory controller: FSM state
// encoding, write-buffer entry layout and the read-timeout fill pattern.
package cpu_mem_pkg;

    // Entry fields are sized for the widest supported ADDR_W/DATA_W.
    localparam int unsigned WBUF_ADDR_W = 32;
    localparam int unsigned WBUF_DATA_W = 32;

    localparam logic [31:0] RD_TIMEOUT_DATA = 32'hDEADBEEF;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        RD_WAIT_WB,
        RD_REQ,
        RD_DATA,
        RESP
    } state_e;

    typedef struct packed {
        logic [WBUF_ADDR_W-1:0] addr;
        logic [WBUF_DATA_W-1:0] data;
    } wbuf_entry_t;

endpackage

// File: rtl/cpu_wbuf.sv
// Posted-write FIFO. Pointers carry one extra wrap bit so full and empty
// are distinguishable without a separate occupancy counter.
module cpu_wbuf
    import cpu_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  logic        pop_i,
    input  wbuf_entry_t din_i,
    output logic        full_o,
    output logic        empty_o,
    output wbuf_entry_t head_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    wbuf_entry_t    mem_q [DEPTH];
    logic           do_push;
    logic           do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

    // A pop in the same cycle frees the slot, so a push into a full buffer
    // is still accepted then.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/cpu_mem_ctrl.sv
// CPU-to-bus memory controller with a posted write buffer; writes drain ahead
// of reads. Define MEM_RD_TIMEOUT_EN to add a read-response timeout.
module cpu_mem_ctrl
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WBUF_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_en,
    input  logic              cpu_wr_en,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_valid,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              err
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              rd_pend_q, rd_pend_d;

    logic              wb_pop;
    logic              wb_full;
    logic              wb_empty;
    wbuf_entry_t       wb_din;
    wbuf_entry_t       wb_head;

`ifdef MEM_RD_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    assign wb_din = '{addr: WBUF_ADDR_W'(cpu_addr), data: WBUF_DATA_W'(cpu_wdata)};

    cpu_wbuf #(
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (cpu_wr_en),
        .pop_i   (wb_pop),
        .din_i   (wb_din),
        .full_o  (wb_full),
        .empty_o (wb_empty),
        .head_o  (wb_head)
    );

    assign cpu_rdata = rdata_q;
    assign err       = err_q;

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        rdata_d   = rdata_q;
        rd_pend_d = rd_pend_q;
        err_d     = err_q | (cpu_wr_en && wb_full && !wb_pop);
        wb_pop    = 1'b0;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        cpu_valid = 1'b0;
`ifdef MEM_RD_TIMEOUT_EN
        tmo_d     = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (!wb_empty) begin
                    state_d = WR_REQ;
                end else if (cpu_en) begin
                    rd_addr_d = cpu_addr;
                    rd_pend_d = 1'b1;
                    state_d   = RD_REQ;
                end
            end
            WR_REQ: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = wb_head.addr[ADDR_W-1:0];
                bus_wdata = wb_head.data[DATA_W-1:0];
                if (bus_gnt) begin
                    wb_pop  = 1'b1;
                    state_d = rd_pend_q ? RD_WAIT_WB : IDLE;
                end
            end
            RD_WAIT_WB: begin
                state_d = wb_empty ? RD_REQ : WR_REQ;
            end
            RD_REQ: begin
                bus_req  = 1'b1;
                bus_addr = rd_addr_q;
                // An ungranted read yields to any newer write so it sees that data.
                if (bus_gnt) begin
                    rd_pend_d = 1'b0;
                    state_d   = RD_DATA;
`ifdef MEM_RD_TIMEOUT_EN
                    tmo_d     = '0;
`endif
                end else if (cpu_wr_en || !wb_empty) begin
                    state_d = RD_WAIT_WB;
                end
            end
            RD_DATA: begin
                if (bus_rvalid) begin
                    rdata_d = bus_rdata;
                    state_d = RESP;
                end
`ifdef MEM_RD_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    rdata_d = DATA_W'(RD_TIMEOUT_DATA);
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            RESP: begin
                cpu_valid = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            rd_pend_q <= 1'b0;
`ifdef MEM_RD_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            rd_pend_q <= rd_pend_d;
`ifdef MEM_RD_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

endmodule
